// File: rtl/nios_debug_jtag_host_if.sv
// Command/response handshake bundle for nios_debug_jtag_host.
// master: the test/bring-up controller issuing commands.
// slave : the JTAG host that executes them.
interface nios_debug_jtag_host_if #(
   parameter int DR_WIDTH = 38
);
   logic                cmd_valid;
   logic                cmd_ready;
   logic [1:0]          cmd_ir;
   logic [DR_WIDTH-1:0] cmd_dr;
   logic                cmd_skip_ir;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [DR_WIDTH-1:0] rsp_dr;
   logic [1:0]          rsp_ir;

   modport master (
      output cmd_valid, cmd_ir, cmd_dr, cmd_skip_ir, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_dr, rsp_ir
   );

   modport slave (
      input  cmd_valid, cmd_ir, cmd_dr, cmd_skip_ir, rsp_ready,
      output cmd_ready, rsp_valid, rsp_dr, rsp_ir
   );
endinterface

// File: rtl/nios_debug_jtag_host.sv
// Virtual-JTAG host for the Nios II debug slave, clocked from the system clock.
// Runs UIR -> CDR -> SDR(x DR_WIDTH) -> E1DR -> RTI per command and returns the
// TDO bits captured during SDR. TCK is generated as low half then high half;
// strobes/TDI/IR change on the falling edge, TDO/IR_OUT are sampled on the rising edge.
// Optional feature: define NIOS_DEBUG_HOST_IR_CAPTURE_EN to capture ir_out into rsp_ir
// during UIR; otherwise rsp_ir is tied to zero.
module nios_debug_jtag_host #(
   parameter int DR_WIDTH = 38,
   parameter int TCK_HALF = 2
) (
   input  logic                    clk,
   input  logic                    reset_n,
   nios_debug_jtag_host_if.slave   bus,
   output logic                    tck,
   output logic                    tdi,
   input  logic                    tdo,
   output logic [1:0]              ir_in,
   input  logic [1:0]              ir_out,
   output logic                    vs_uir,
   output logic                    vs_cdr,
   output logic                    vs_sdr,
   output logic                    vs_e1dr,
   output logic                    jtag_state_rti
);

   localparam int PH_W  = (TCK_HALF > 1) ? $clog2(2 * TCK_HALF) : 1;
   localparam int BIT_W = $clog2(DR_WIDTH);
   localparam logic [PH_W-1:0]  PH_RISE  = PH_W'(TCK_HALF - 1);
   localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2 * TCK_HALF - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DR_WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_UIR, S_CDR, S_SDR, S_E1DR, S_RTI, S_DONE
   } state_t;

   state_t              state_reg, state_next;
   logic [PH_W-1:0]     ph_reg;
   logic [BIT_W-1:0]    bit_reg;
   logic [DR_WIDTH-1:0] shift_reg;
   logic [DR_WIDTH-1:0] rsp_dr_reg;
   logic [1:0]          ir_in_reg;
   logic                tck_reg;
   logic                rsp_valid_reg;
   logic                cmd_ready;
   logic                accept;
   logic                active;
   logic                tck_rise;
   logic                period_end;

   assign cmd_ready  = (state_reg == S_IDLE) && !rsp_valid_reg;
   assign accept     = bus.cmd_valid && cmd_ready;
   assign active     = (state_reg != S_IDLE) && (state_reg != S_DONE);
   // tck_rise: this clk edge drives tck high; period_end: this edge drives it low.
   assign tck_rise   = active && (ph_reg == PH_RISE);
   assign period_end = active && (ph_reg == PH_LAST);

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_reg <= S_IDLE;
      else          state_reg <= state_next;
   end

   // Next-state logic: every TAP state advances only at a TCK period boundary.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: if (accept) state_next = bus.cmd_skip_ir ? S_CDR : S_UIR;
         S_UIR:  if (period_end) state_next = S_CDR;
         S_CDR:  if (period_end) state_next = S_SDR;
         S_SDR:  if (period_end && (bit_reg == BIT_LAST)) state_next = S_E1DR;
         S_E1DR: if (period_end) state_next = S_RTI;
         S_RTI:  if (period_end) state_next = S_DONE;
         S_DONE: state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // TCK phase counter and TCK itself; both idle low outside active states.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ph_reg  <= '0;
         tck_reg <= 1'b0;
      end else begin
         ph_reg <= (active && !period_end) ? ph_reg + PH_W'(1) : '0;
         if (tck_rise)        tck_reg <= 1'b1;
         else if (period_end) tck_reg <= 1'b0;
      end
   end

   // DR bit counter, counts SDR periods; cleared in every other state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                                  bit_reg <= '0;
      else if (state_reg != S_SDR)                   bit_reg <= '0;
      else if (period_end)                           bit_reg <= bit_reg + BIT_W'(1);
   end

   // TDI shifter: loaded on accept, advanced at the end of each SDR period.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                                  shift_reg <= '0;
      else if (accept)                               shift_reg <= bus.cmd_dr;
      else if ((state_reg == S_SDR) && period_end)   shift_reg <= shift_reg >> 1;
   end

   // TDO capture: shifting in from the MSB leaves the k-th sampled bit at index k.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                                  rsp_dr_reg <= '0;
      else if ((state_reg == S_SDR) && tck_rise)     rsp_dr_reg <= {tdo, rsp_dr_reg[DR_WIDTH-1:1]};
   end

   // IR presented to the slave; a skipped UIR keeps the previous value.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                                  ir_in_reg <= 2'b00;
      else if (accept && !bus.cmd_skip_ir)           ir_in_reg <= bus.cmd_ir;
   end

   // Response valid: raised leaving DONE, held until the consumer takes it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                                  rsp_valid_reg <= 1'b0;
      else if (state_reg == S_DONE)                  rsp_valid_reg <= 1'b1;
      else if (rsp_valid_reg && bus.rsp_ready)       rsp_valid_reg <= 1'b0;
   end

`ifdef NIOS_DEBUG_HOST_IR_CAPTURE_EN
   logic [1:0] rsp_ir_reg;

   // IR readback sampled on the UIR rising TCK edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                                  rsp_ir_reg <= 2'b00;
      else if ((state_reg == S_UIR) && tck_rise)     rsp_ir_reg <= ir_out;
   end

   assign bus.rsp_ir = rsp_ir_reg;
`else
   logic ir_out_unused;
   assign ir_out_unused = ^ir_out;
   assign bus.rsp_ir    = 2'b00;
`endif

   assign bus.cmd_ready  = cmd_ready;
   assign bus.rsp_valid  = rsp_valid_reg;
   assign bus.rsp_dr     = rsp_dr_reg;
   assign tck            = tck_reg;
   assign tdi            = shift_reg[0];
   assign ir_in          = ir_in_reg;
   assign vs_uir         = (state_reg == S_UIR);
   assign vs_cdr         = (state_reg == S_CDR);
   assign vs_sdr         = (state_reg == S_SDR);
   assign vs_e1dr        = (state_reg == S_E1DR);
   assign jtag_state_rti = (state_reg == S_RTI);

endmodule

// File: doc/nios_debug_jtag_host.md
# nios_debug_jtag_host

Single-clock virtual-JTAG host that drives the Nios II debug slave's TAP-side port from the system clock. It accepts a command (2-bit IR and 38-bit DR), then generates TCK, TDI, IR and virtual-state strobes in the order the debug slave expects: UIR, CDR, SDR, E1DR, RTI. It captures TDO into a 38-bit response. It sits between an on-chip test/bring-up controller and the debug slave's virtual-JTAG inputs, replacing the `sld_virtual_jtag_basic` hub in simulation and self-test builds.

## Interface
Parameters:
- `DR_WIDTH`, 38, DR shift length in bits; legal range 2..64.
- `TCK_HALF`, 2, TCK half-period in `clk` cycles; minimum 1.

Ports:
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: a command is offered.
- `cmd_ready` out 1: the block can accept a command.
- `cmd_ir` in 2: IR value, presented on `ir_in` during the transaction.
- `cmd_dr` in DR_WIDTH: data shifted out on TDI, LSB first.
- `cmd_skip_ir` in 1: when 1, the UIR period is omitted and `ir_in` keeps its previous value.
- `rsp_valid` out 1: a response is available.
- `rsp_ready` in 1: the consumer accepts the response.
- `rsp_dr` out DR_WIDTH: TDO bits captured during the transaction.
- `rsp_ir` out 2: `ir_out` value sampled during UIR.
- `tck` out 1: generated TCK.
- `tdi` out 1: serial data to the slave.
- `tdo` in 1: serial data from the slave.
- `ir_in` out 2: IR value presented to the slave.
- `ir_out` in 2: IR value returned by the slave.
- `vs_uir`, `vs_cdr`, `vs_sdr`, `vs_e1dr`, `jtag_state_rti` out 1 each: virtual-state strobes; one-hot or all zero.

## Operation
- FSM states: IDLE → UIR → CDR → SDR → E1DR → RTI → DONE → IDLE.
  - With `cmd_skip_ir`=1 the sequence is IDLE → CDR.
- Each state other than IDLE and DONE lasts exactly one TCK period, except SDR, which lasts DR_WIDTH periods (bit counter runs 0..DR_WIDTH-1).
- In each state, the matching strobe is 1 and all other strobes are 0. In IDLE and DONE, all strobes are 0.
- Command acceptance:
  - `cmd_ready`=1 only in IDLE while `rsp_valid`=0.
  - Accept happens on `cmd_valid && cmd_ready`.
  - On accept, the block latches `cmd_dr` into the shift register.
  - On accept without skip, it also latches `cmd_ir` into `ir_in`.
- Shifting:
  - `tdi` = shift register bit 0.
  - The shift register shifts right once per SDR period.
  - TDO bit k (k-th SDR period, 0-based) is written to `rsp_dr[k]`.
- DONE sets `rsp_valid`=1 and returns to IDLE.
- `rsp_valid` holds, with `rsp_dr` and `rsp_ir` stable, until `rsp_ready`=1.
  - `rsp_valid` and `rsp_ready` in the same cycle clears `rsp_valid` on the next edge. `cmd_ready` rises in that next cycle.
- `cmd_valid` deasserting while a command is in flight has no effect.
- Reset values: `cmd_ready`=1, `rsp_valid`=0, `rsp_dr`=0, `rsp_ir`=0, `tck`=0, `tdi`=0, `ir_in`=0, all strobes 0.

## Timing
- TCK period = 2·TCK_HALF `clk` cycles.
  - Low half comes first, then high half.
  - `tck` is low throughout IDLE and DONE.
- Falling-edge updates: strobes, `tdi` and `ir_in` change only on the `clk` edge that drives `tck` low, i.e. at a period boundary.
- Rising-edge sampling: `tdo` and `ir_out` are sampled on the `clk` edge that drives `tck` high.
  - `ir_out` is sampled during UIR.
  - `tdo` is sampled during each SDR period.
- Latency from accept to `rsp_valid`=1:
  - 2·TCK_HALF·(DR_WIDTH+4)+1 `clk` cycles.
  - Subtract 2·TCK_HALF when `cmd_skip_ir`=1.
- Back-to-back throughput: one idle `clk` cycle minimum between RTI end and the next UIR/CDR start.
- `reset_n` asserted mid-transaction:
  - All outputs return to their reset values asynchronously.
  - The partial response is discarded; no `rsp_valid` follows.

## Configuration
- `NIOS_DEBUG_HOST_IR_CAPTURE_EN` defined: `ir_out` is sampled on the UIR rising TCK edge into `rsp_ir`.
  - A skipped UIR leaves `rsp_ir` unchanged.
- `NIOS_DEBUG_HOST_IR_CAPTURE_EN` undefined: `rsp_ir` is constant 0 and `ir_out` is ignored.

## Test plan
- Reset check: TCK_HALF=2, DR_WIDTH=38, hold `reset_n`=0 → all outputs at their reset values, `tck` never toggles.
- Loopback shift: `cmd_ir`=2'b01, `cmd_dr`=38'h2A_5A5A_5A5A, `tdo` driven from a 38-bit slave model → `rsp_dr` equals the model's preload; the model receives 38'h2A_5A5A_5A5A; `rsp_valid` arrives 169 cycles after accept.
- Skip IR: `cmd_skip_ir`=1 after a prior `cmd_ir`=2'b11 → no `vs_uir` pulse; `ir_in` stays 2'b11; latency is 165 cycles.
- Response backpressure: hold `rsp_ready`=0 for 20 cycles with `cmd_valid`=1 → `cmd_ready`=0 and `rsp_dr` stable; then pulse `rsp_ready` → next transaction begins, `cmd_ready` high one cycle after.
- Reset mid-SDR: assert `reset_n`=0 at SDR bit 10 → strobes, `tck` and `tdi` go to 0 immediately; no `rsp_valid` after release.
- IR capture: with `NIOS_DEBUG_HOST_IR_CAPTURE_EN`, `ir_out`=2'b10 during UIR → `rsp_ir`=2'b10; without the macro → `rsp_ir`=2'b00.
